// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser: FSM states, coin
// selection codes and coin face values.
package change_pkg;

  localparam int CHANGE_W = 5;

  localparam logic [CHANGE_W-1:0] COIN_10 = 5'd10;
  localparam logic [CHANGE_W-1:0] COIN_5  = 5'd5;
  localparam logic [CHANGE_W-1:0] COIN_1  = 5'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    COIN_NONE   = 2'd0,
    COIN_SEL_10 = 2'd1,
    COIN_SEL_5  = 2'd2,
    COIN_SEL_1  = 2'd3
  } coin_t;

  function automatic logic [CHANGE_W-1:0] coin_value(input coin_t c);
    case (c)
      COIN_SEL_10: coin_value = COIN_10;
      COIN_SEL_5:  coin_value = COIN_5;
      COIN_SEL_1:  coin_value = COIN_1;
      default:     coin_value = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_coin_pulse_timer.sv
// Down-counter timing eject pulses and inter-coin gaps; o_expire marks the
// last cycle of the loaded interval.
module coin_pulse_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_len;
    end else if (r_cnt != {CNT_W{1'b0}}) begin
      r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expire = (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/change_dispenser.sv
// Greedy change payout sequencer (10, 5, 1) with timed eject pulses.
// Optional feature macro CHANGE_INV_EN: finite per-coin inventory, refill, short-pay.
module change_dispenser
  import change_pkg::*;
#(
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2,
  parameter int INV_W     = 4,
  parameter int INIT_10   = 8,
  parameter int INIT_5    = 8,
  parameter int INIT_1    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [4:0] i_change,
  input  logic       i_refill,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_short,
  output logic       o_eject_10,
  output logic       o_eject_5,
  output logic       o_eject_1,
  output logic [4:0] o_num_10,
  output logic [4:0] o_num_5,
  output logic [4:0] o_num_1,
  output logic [4:0] o_remain
);

  localparam int TMR_W = 8;

  state_t              r_state;
  coin_t               r_coin;
  logic                r_busy;
  logic                r_done;
  logic                r_eject_10;
  logic                r_eject_5;
  logic                r_eject_1;
  logic [CHANGE_W-1:0] r_remain;
  logic [CHANGE_W-1:0] r_num_10;
  logic [CHANGE_W-1:0] r_num_5;
  logic [CHANGE_W-1:0] r_num_1;

  state_t              w_state_nxt;
  coin_t               w_pick;
  coin_t               w_coin_nxt;
  logic                w_short_set;
  logic                w_tmr_load;
  logic [TMR_W-1:0]    w_tmr_len;
  logic                w_tmr_expire;
  logic                w_has_10;
  logic                w_has_5;
  logic                w_has_1;
  logic                w_accept;

  assign w_accept = (r_state == ST_IDLE) && i_start;

`ifdef CHANGE_INV_EN
  logic [INV_W-1:0] r_inv_10;
  logic [INV_W-1:0] r_inv_5;
  logic [INV_W-1:0] r_inv_1;
  logic             r_short;

  assign w_has_10 = (r_inv_10 != {INV_W{1'b0}});
  assign w_has_5  = (r_inv_5  != {INV_W{1'b0}});
  assign w_has_1  = (r_inv_1  != {INV_W{1'b0}});

  // Inventory: reload on reset/refill (refill only while idle), debit on each pick.
  always_ff @(posedge clk) begin
    if (reset || ((r_state == ST_IDLE) && i_refill)) begin
      r_inv_10 <= INV_W'(INIT_10);
      r_inv_5  <= INV_W'(INIT_5);
      r_inv_1  <= INV_W'(INIT_1);
    end else begin
      case (w_pick)
        COIN_SEL_10: r_inv_10 <= r_inv_10 - {{(INV_W-1){1'b0}}, 1'b1};
        COIN_SEL_5:  r_inv_5  <= r_inv_5  - {{(INV_W-1){1'b0}}, 1'b1};
        COIN_SEL_1:  r_inv_1  <= r_inv_1  - {{(INV_W-1){1'b0}}, 1'b1};
        default: begin
          r_inv_10 <= r_inv_10;
          r_inv_5  <= r_inv_5;
          r_inv_1  <= r_inv_1;
        end
      endcase
    end
  end

  // Short-pay flag: cleared by an accepted start, set when no coin fits.
  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_short <= 1'b0;
    end else if (w_short_set) begin
      r_short <= 1'b1;
    end else begin
      r_short <= r_short;
    end
  end

  assign o_short = r_short;
`else
  logic w_unused;

  assign w_has_10 = 1'b1;
  assign w_has_5  = 1'b1;
  assign w_has_1  = 1'b1;
  assign o_short  = 1'b0;
  assign w_unused = ^{i_refill, w_short_set, (INIT_10 > 0), (INIT_5 > 0),
                      (INIT_1 > 0), (INV_W > 0)};
`endif

  coin_pulse_timer #(.CNT_W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_tmr_load),
    .i_len    (w_tmr_len),
    .o_expire (w_tmr_expire)
  );

  // Next-state, coin choice and timer loading.
  always_comb begin
    w_state_nxt = r_state;
    w_pick      = COIN_NONE;
    w_short_set = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_len   = 8'd0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_SELECT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SELECT: begin
        if (r_remain == 5'd0) begin
          w_state_nxt = ST_DONE;
        end else if ((r_remain >= COIN_10) && w_has_10) begin
          w_pick = COIN_SEL_10;
        end else if ((r_remain >= COIN_5) && w_has_5) begin
          w_pick = COIN_SEL_5;
        end else if ((r_remain >= COIN_1) && w_has_1) begin
          w_pick = COIN_SEL_1;
        end else begin
          w_short_set = 1'b1;
          w_state_nxt = ST_DONE;
        end
        if (w_pick != COIN_NONE) begin
          w_state_nxt = ST_PULSE;
          w_tmr_load  = 1'b1;
          w_tmr_len   = TMR_W'(PULSE_CYC);
        end else begin
          w_tmr_load  = 1'b0;
        end
      end
      ST_PULSE: begin
        if (w_tmr_expire) begin
          w_state_nxt = ST_GAP;
          w_tmr_load  = 1'b1;
          w_tmr_len   = TMR_W'(GAP_CYC);
        end else begin
          w_state_nxt = ST_PULSE;
        end
      end
      ST_GAP: begin
        if (w_tmr_expire) begin
          w_state_nxt = ST_SELECT;
        end else begin
          w_state_nxt = ST_GAP;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_coin_nxt = (w_pick != COIN_NONE) ? w_pick : r_coin;
  end

  // State plus status/eject outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_coin     <= COIN_NONE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_eject_10 <= 1'b0;
      r_eject_5  <= 1'b0;
      r_eject_1  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_coin     <= w_coin_nxt;
      r_busy     <= (w_state_nxt == ST_SELECT) || (w_state_nxt == ST_PULSE) ||
                    (w_state_nxt == ST_GAP);
      r_done     <= (w_state_nxt == ST_DONE);
      r_eject_10 <= (w_state_nxt == ST_PULSE) && (w_coin_nxt == COIN_SEL_10);
      r_eject_5  <= (w_state_nxt == ST_PULSE) && (w_coin_nxt == COIN_SEL_5);
      r_eject_1  <= (w_state_nxt == ST_PULSE) && (w_coin_nxt == COIN_SEL_1);
    end
  end

  // Remaining amount and per-coin counts for the current transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_remain <= 5'd0;
      r_num_10 <= 5'd0;
      r_num_5  <= 5'd0;
      r_num_1  <= 5'd0;
    end else if (w_accept) begin
      r_remain <= i_change;
      r_num_10 <= 5'd0;
      r_num_5  <= 5'd0;
      r_num_1  <= 5'd0;
    end else begin
      r_remain <= r_remain - coin_value(w_pick);
      case (w_pick)
        COIN_SEL_10: r_num_10 <= r_num_10 + 5'd1;
        COIN_SEL_5:  r_num_5  <= r_num_5  + 5'd1;
        COIN_SEL_1:  r_num_1  <= r_num_1  + 5'd1;
        default: begin
          r_num_10 <= r_num_10;
          r_num_5  <= r_num_5;
          r_num_1  <= r_num_1;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_eject_10 = r_eject_10;
  assign o_eject_5  = r_eject_5;
  assign o_eject_1  = r_eject_1;
  assign o_num_10   = r_num_10;
  assign o_num_5    = r_num_5;
  assign o_num_1    = r_num_1;
  assign o_remain   = r_remain;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a default instance (8/8/8 inventory) and
// a lean-inventory instance (0/1/2) share the same stimulus.
module tb_change_dispenser;

`ifdef CHANGE_INV_EN
  localparam int INV = 1;
`else
  localparam int INV = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       i_start;
  logic       i_refill;
  logic [4:0] i_change;

  logic [1:0]      busy, done, short_f, e10, e5, e1;
  logic [1:0][4:0] n10, n5, n1, rem;

  change_dispenser dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_change(i_change),
    .i_refill(i_refill), .o_busy(busy[0]), .o_done(done[0]), .o_short(short_f[0]),
    .o_eject_10(e10[0]), .o_eject_5(e5[0]), .o_eject_1(e1[0]),
    .o_num_10(n10[0]), .o_num_5(n5[0]), .o_num_1(n1[0]), .o_remain(rem[0])
  );

  change_dispenser #(.INIT_10(0), .INIT_5(1), .INIT_1(2)) dut_s (
    .clk(clk), .reset(reset), .i_start(i_start), .i_change(i_change),
    .i_refill(i_refill), .o_busy(busy[1]), .o_done(done[1]), .o_short(short_f[1]),
    .o_eject_10(e10[1]), .o_eject_5(e5[1]), .o_eject_1(e1[1]),
    .o_num_10(n10[1]), .o_num_5(n5[1]), .o_num_1(n1[1]), .o_remain(rem[1])
  );

  int n_pass  = 0;
  int n_total = 0;

  int done_c[2], p10[2], p5[2], p1[2], busy_n[2], badw[2], ovl[2], first_r[2];
  int run_len[2], pv10[2], pv5[2], pv1[2];

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int all_outs(input int d);
    all_outs = int'({busy[d], done[d], short_f[d], e10[d], e5[d], e1[d],
                     n10[d], n5[d], n1[d], rem[d]});
  endfunction

  task automatic sample(input int d, input int c);
    int hi;
    hi = int'(e10[d]) + int'(e5[d]) + int'(e1[d]);
    if (e10[d] && pv10[d] == 0) p10[d]++;
    if (e5[d]  && pv5[d]  == 0) p5[d]++;
    if (e1[d]  && pv1[d]  == 0) p1[d]++;
    pv10[d] = int'(e10[d]); pv5[d] = int'(e5[d]); pv1[d] = int'(e1[d]);
    if (hi > 1) ovl[d]++;
    if (hi > 0) begin
      run_len[d]++;
      if (first_r[d] < 0) first_r[d] = c;
    end else begin
      if (run_len[d] != 0 && run_len[d] != 4) badw[d]++;
      run_len[d] = 0;
    end
    if (busy[d]) busy_n[d]++;
    if (done[d] && done_c[d] < 0) done_c[d] = c;
  endtask

  // Accept a start on the next edge, then watch both instances cycle by cycle.
  task automatic run(input logic [4:0] chg, input logic rf, input int poke_c,
                     input logic [4:0] poke_chg);
    @(negedge clk);
    i_start = 1'b1; i_change = chg; i_refill = rf;
    @(negedge clk);
    i_refill = 1'b0;
    for (int d = 0; d < 2; d++) begin
      done_c[d] = -1; p10[d] = 0; p5[d] = 0; p1[d] = 0; busy_n[d] = 0;
      badw[d] = 0; ovl[d] = 0; first_r[d] = -1; run_len[d] = 0;
      pv10[d] = 0; pv5[d] = 0; pv1[d] = 0;
    end
    for (int c = 1; c <= 100; c++) begin
      if (c > 1) @(negedge clk);
      sample(0, c);
      sample(1, c);
      if (c == poke_c) begin
        i_start = 1'b1; i_change = poke_chg;
      end else begin
        i_start = 1'b0;
      end
      if (done_c[0] >= 0 && done_c[1] >= 0) break;
    end
    i_start = 1'b0;
  endtask

  task automatic expect_run(input int d, input string t, input int dc, input int x10,
                            input int x5, input int x1, input int xrem, input int xsh);
    check({t, "_done_cyc"}, done_c[d], dc);
    check({t, "_num10"}, int'(n10[d]), x10);
    check({t, "_num5"},  int'(n5[d]),  x5);
    check({t, "_num1"},  int'(n1[d]),  x1);
    check({t, "_pulses"}, p10[d] * 10000 + p5[d] * 100 + p1[d], x10 * 10000 + x5 * 100 + x1);
    check({t, "_remain"}, int'(rem[d]), xrem);
    check({t, "_short"}, int'(short_f[d]), xsh);
    check({t, "_width_gap"}, badw[d] + ovl[d], 0);
    check({t, "_first_rise"}, first_r[d], (x10 + x5 + x1 > 0) ? 2 : -1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_start = 1'b0; i_refill = 1'b0; i_change = 5'd0;
    do_reset();
    check("reset_outs_a", all_outs(0), 0);
    check("reset_outs_s", all_outs(1), 0);

    // 9: greedy 5+1+1+1+1; lean inventory runs out after 5,1,1
    run(5'd9, 1'b0, 0, 5'd0);
    expect_run(0, "c9_a", 37, 0, 1, 4, 0, 0);
    expect_run(1, "c9_s", INV ? 23 : 37, 0, 1, INV ? 2 : 4, INV ? 2 : 0, INV);

    // 16: one coin of each; lean instance is empty when inventory is modelled
    run(5'd16, 1'b0, 0, 5'd0);
    expect_run(0, "c16_a", 23, 1, 1, 1, 0, 0);
    check("c16_a_busy_cycles", busy_n[0], 22);
    expect_run(1, "c16_s", INV ? 2 : 23, INV ? 0 : 1, INV ? 0 : 1, INV ? 0 : 1,
               INV ? 16 : 0, INV);

    // 0: straight to DONE; start clears the held short flag
    run(5'd0, 1'b0, 0, 5'd0);
    expect_run(0, "c0_a", 2, 0, 0, 0, 0, 0);
    check("c0_a_busy_cycles", busy_n[0], 1);
    expect_run(1, "c0_s", 2, 0, 0, 0, 0, 0);

    // start with a new amount mid-pulse must be ignored
    do_reset();
    run(5'd16, 1'b0, 3, 5'd7);
    expect_run(0, "poke_a", 23, 1, 1, 1, 0, 0);
    expect_run(1, "poke_s", 23, INV ? 0 : 1, 1, INV ? 2 : 1, INV ? 9 : 0, INV);

    // 30 with INIT_10=0 on the lean instance; then drain the tens of the default one
    do_reset();
    run(5'd30, 1'b0, 0, 5'd0);
    expect_run(0, "c30_a", 23, 3, 0, 0, 0, 0);
    expect_run(1, "c30_s", 23, INV ? 0 : 3, INV ? 1 : 0, INV ? 2 : 0, INV ? 23 : 0, INV);
    run(5'd30, 1'b0, 0, 5'd0);
    check("c30b_a_num10", int'(n10[0]), 3);
    run(5'd20, 1'b0, 0, 5'd0);
    expect_run(0, "c20_a", 16, 2, 0, 0, 0, 0);
    run(5'd10, 1'b0, 0, 5'd0);
    expect_run(0, "c10_empty_a", INV ? 16 : 9, INV ? 0 : 1, INV ? 2 : 0, 0, 0, 0);
    run(5'd10, 1'b1, 0, 5'd0);
    expect_run(0, "c10_refill_a", 9, 1, 0, 0, 0, 0);

    // reset in the middle of the first pulse
    do_reset();
    @(negedge clk);
    i_start = 1'b1; i_change = 5'd16;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_pre_e10", int'(e10[0]), 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_outs_a", all_outs(0), 0);
    check("midrst_outs_s", all_outs(1), 0);
    reset = 1'b0;
    run(5'd9, 1'b0, 0, 5'd0);
    expect_run(0, "postrst_a", 37, 0, 1, 4, 0, 0);
    expect_run(1, "postrst_s", INV ? 23 : 37, 0, 1, INV ? 2 : 4, INV ? 2 : 0, INV);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Sequences coin ejection for the vending machine's change output. It accepts a change amount once the sale finishes and pays it out greedily: 10-unit coins first, then 5, then 1. Each coin is one timed pulse on a per-denomination eject line, and the block tracks per-denomination inventory and a short-pay condition. It sits between the vending machine core's change output and the coin-hopper drivers, and supplies the per-denomination counts shown on the HEX digits.

## Interface
- PULSE_CYC, 4: eject pulse width in clk cycles (≥1)
- GAP_CYC, 2: idle cycles after each pulse (≥1)
- INV_W, 4: inventory counter width per denomination
- INIT_10 / INIT_5 / INIT_1, 8 each: inventory loaded on reset and on refill
- clk  in  1  single clock, the divided 1 kHz system clock
- reset  in  1  synchronous, active-high
- i_start  in  1  request payout of i_change; sampled only in IDLE
- i_change  in  5  change amount, 0..31
- i_refill  in  1  reload inventories to INIT_*; honoured only in IDLE
- o_busy  out  1  high in SELECT/PULSE/GAP
- o_done  out  1  one-cycle pulse at end of payout
- o_short  out  1  payout ended with remainder > 0; held until next accepted start
- o_eject_10 / o_eject_5 / o_eject_1  out  1 each  hopper drive pulses, at most one high at a time
- o_num_10 / o_num_5 / o_num_1  out  5 each  coins ejected this transaction; held until next start
- o_remain  out  5  unpaid amount

## Operation
- Reset values:
  - State is IDLE.
  - All o_* outputs are 0, including counts and o_remain.
  - Inventories load INIT_*.
- FSM states: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE with i_start=1:
  - Load remain ← i_change.
  - Clear counts and o_short.
  - Go to SELECT.
- SELECT (one cycle), taking the first match:
  - remain==0 → DONE.
  - remain≥10 and inv10>0 → coin 10.
  - remain≥5 and inv5>0 → coin 5.
  - remain≥1 and inv1>0 → coin 1.
  - No match → set o_short, go to DONE.
  - On a coin pick: remain −= value, inv −= 1, count += 1, all at the SELECT→PULSE edge. Go to PULSE.
- PULSE:
  - The chosen eject line is high for exactly PULSE_CYC cycles.
  - Then go to GAP.
- GAP:
  - All eject lines are low for GAP_CYC cycles.
  - Then go to SELECT.
- DONE:
  - o_done=1 for one cycle, o_busy=0.
  - Go to IDLE.
- Arithmetic: remain never underflows, because a coin is chosen only if value ≤ remain. Inventory never decrements below 0.
- i_start and i_refill are ignored outside IDLE. No queuing.
- i_refill and i_start in the same IDLE cycle: the refill applies first, and the accepted payout uses the refilled inventory.
- Reset mid-payout: the next cycle is IDLE with all outputs 0 and inventories at INIT_*. The partial payout is abandoned.

## Timing
- i_start accepted at edge k: SELECT at k+1, o_busy high from k+1.
- Per coin: 1 (SELECT) + PULSE_CYC + GAP_CYC cycles. The first eject pulse rises at k+2.
- Final SELECT costs 1 cycle, then DONE for 1 cycle. Total = 2 + N·(1+PULSE_CYC+GAP_CYC), where N is the number of coins ejected.
- Change 0: o_done high during cycle k+2, with no eject pulses.
- Counts and o_remain update at the SELECT→PULSE edge and are visible during the pulse.

## Configuration
- CHANGE_INV_EN defined:
  - Inventory registers, i_refill, INIT_* loading and o_short logic are compiled in, as described above.
- CHANGE_INV_EN undefined:
  - Inventories are treated as unlimited and no inventory registers are built.
  - i_refill is ignored.
  - o_short is tied 0.
  - Every payout completes with o_remain=0.

## Structure
- Shared package change_pkg holds:
  - the state enum;
  - coin value constants COIN_10=10, COIN_5=5, COIN_1=1;
  - CHANGE_W=5.
- Sub-module coin_pulse_timer:
  - A down-counter loaded with PULSE_CYC or GAP_CYC.
  - Asserts an expiry strobe to the FSM.
  - Clears on reset.

## Test plan
- Default params, i_change=16 → one pulse each on eject_10, eject_5, eject_1, each 4 cycles wide with 2-cycle gaps. Counts end 1/1/1, o_remain=0, o_short=0. o_done at k+2+21.
- i_change=0 → no eject activity, o_done at k+2, o_busy high only during cycle k+1.
- INIT_10=0, INIT_5=1, INIT_1=2, i_change=9 → ejects 5, 1, 1, then o_short=1, o_remain=2, counts 0/1/2.
- Pulse i_start during PULSE with a new i_change → ignored, and the original payout completes unchanged. Exhaust the 10s, then assert i_refill and i_start together in IDLE → 10-coins are used again.
- Assert reset mid-PULSE → eject lines low and state IDLE on the next cycle, counts 0, inventories at INIT_*.
- CHANGE_INV_EN undefined, INIT_10=0, i_change=30 → three eject_10 pulses, o_short=0.
